// File: rtl/linear_conv_engine_if.sv
// Load/start/result bundle for linear_conv_engine.
// The master side loads samples and taps and starts a run; the slave side is the engine.
interface linear_conv_engine_if #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int YW    = 4,
  parameter int ACC_W = 19
);
  logic                    load_x;
  logic                    load_h;
  logic [AW-1:0]           wr_addr;
  logic signed [DW-1:0]    din;
  logic                    start;
  logic                    busy;
  logic                    y_valid;
  logic [YW-1:0]           y_idx;
  logic signed [ACC_W-1:0] y_data;
  logic                    done;

  modport master (
    output load_x, load_h, wr_addr, din, start,
    input  busy, y_valid, y_idx, y_data, done
  );

  modport slave (
    input  load_x, load_h, wr_addr, din, start,
    output busy, y_valid, y_idx, y_data, done
  );
endinterface

// File: rtl/linear_conv_engine.sv
// Sequential linear convolution y[n] = sum_k x[k]*h[n-k], one MAC per clock.
// Each output takes N MAC cycles followed by one EMIT cycle; a DONE cycle ends the run.
module linear_conv_engine #(
  parameter int DW    = 8,
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int AW    = 3,
  parameter int YW    = 4,
  parameter int ACC_W = 19
) (
  input  logic               clk,
  input  logic               rstn,
  linear_conv_engine_if.slave bus
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [YW-1:0]           n_reg, n_next;
  logic [KW-1:0]           k_reg, k_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic signed [ACC_W-1:0] y_data_reg, y_data_next;
  logic [YW-1:0]           y_idx_reg, y_idx_next;

  logic signed [DW-1:0]    x_mem [N];
  logic signed [DW-1:0]    h_mem [M];

  logic                    load_ok;
  int                      diff;
  logic                    h_ok;
  logic signed [DW-1:0]    x_val;
  logic signed [DW-1:0]    h_val;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_sum;

  // Memories are only writable between runs so a run always sees stable operands.
  assign load_ok = (state_reg == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_x
      // Sample slot gi: written only when the address decodes to it (out-of-range addresses hit nothing).
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) x_mem[gi] <= '0;
        else if (load_ok && bus.load_x && (bus.wr_addr == AW'(gi))) x_mem[gi] <= bus.din;
      end
    end
    for (gi = 0; gi < M; gi++) begin : g_h
      // Tap slot gi: same decode as the samples, independent enable.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) h_mem[gi] <= '0;
        else if (load_ok && bus.load_h && (bus.wr_addr == AW'(gi))) h_mem[gi] <= bus.din;
      end
    end
  endgenerate

  // Current MAC term: x[k]*h[n-k], zero when n-k falls outside the kernel.
  always_comb begin
    diff  = int'(n_reg) - int'(k_reg);
    h_ok  = (diff >= 0) && (diff < M);
    x_val = x_mem[k_reg];
    h_val = h_ok ? h_mem[HW'(diff)] : '0;
  end

  assign prod    = x_val * h_val;
  assign term    = ACC_W'(prod);
  assign acc_sum = (k_reg == '0) ? term : (acc_reg + term);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      n_reg      <= '0;
      k_reg      <= '0;
      acc_reg    <= '0;
      y_data_reg <= '0;
      y_idx_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      n_reg      <= n_next;
      k_reg      <= k_next;
      acc_reg    <= acc_next;
      y_data_reg <= y_data_next;
      y_idx_reg  <= y_idx_next;
    end
  end

  // Next-state and datapath control; the result is captured on the last MAC edge.
  always_comb begin
    state_next  = state_reg;
    n_next      = n_reg;
    k_next      = k_reg;
    acc_next    = acc_reg;
    y_data_next = y_data_reg;
    y_idx_next  = y_idx_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = MAC;
          n_next     = '0;
          k_next     = '0;
        end
      end
      MAC: begin
        acc_next = acc_sum;
        if (k_reg == KW'(N - 1)) begin
          state_next  = EMIT;
          y_data_next = acc_sum;
          y_idx_next  = n_reg;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      EMIT: begin
        if (n_reg == YW'(N + M - 2)) begin
          state_next = DONE;
        end else begin
          state_next = MAC;
          n_next     = n_reg + YW'(1);
          k_next     = '0;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy    = (state_reg != IDLE);
  assign bus.y_valid = (state_reg == EMIT);
  assign bus.done    = (state_reg == DONE);
  assign bus.y_idx   = y_idx_reg;
  assign bus.y_data  = y_data_reg;
endmodule

// File: tb/tb_linear_conv_engine.sv
// Directed bench for linear_conv_engine: default 8x8 build plus a 4-sample build
// used to show that sample addresses beyond N are ignored.
module tb_linear_conv_engine;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  linear_conv_engine_if #(.DW(8), .AW(3), .YW(4), .ACC_W(19)) a ();
  linear_conv_engine_if #(.DW(8), .AW(3), .YW(4), .ACC_W(18)) b ();

  linear_conv_engine #(.DW(8), .N(8), .M(8), .AW(3), .YW(4), .ACC_W(19)) dut_a (
    .clk(clk), .rstn(rstn), .bus(a.slave)
  );
  linear_conv_engine #(.DW(8), .N(4), .M(8), .AW(3), .YW(4), .ACC_W(18)) dut_b (
    .clk(clk), .rstn(rstn), .bus(b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Results captured by the run tasks.
  logic signed [18:0] ya [15];
  logic signed [17:0] yb [11];
  longint exp_y [15];
  int na, first_c, last_c, done_c, done_cnt, idle_c, idx_bad, gap_bad;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic load_a(input bit lx, input bit lh, input int addr, input int v);
    a.load_x = lx; a.load_h = lh; a.wr_addr = 3'(addr); a.din = 8'(v);
    @(negedge clk);
    a.load_x = 1'b0; a.load_h = 1'b0; a.wr_addr = '0; a.din = '0;
  endtask

  task automatic load_b(input bit lx, input bit lh, input int addr, input int v);
    b.load_x = lx; b.load_h = lh; b.wr_addr = 3'(addr); b.din = 8'(v);
    @(negedge clk);
    b.load_x = 1'b0; b.load_h = 1'b0; b.wr_addr = '0; b.din = '0;
  endtask

  // One full run on instance a; c counts edges after the start-sampling edge E0.
  task automatic run_a(input bit disturb);
    int c;
    c = 0; na = 0; first_c = -1; last_c = -1; done_c = -1; done_cnt = 0;
    idle_c = -1; idx_bad = 0; gap_bad = 0;
    a.start = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    while (c < 400 && idle_c < 0) begin
      if (disturb && c >= 20 && c < 30) begin
        a.start = 1'b1; a.load_x = 1'b1; a.load_h = 1'b1; a.wr_addr = 3'd3; a.din = 8'd99;
      end else begin
        a.start = 1'b0; a.load_x = 1'b0; a.load_h = 1'b0; a.wr_addr = '0; a.din = '0;
      end
      @(negedge clk);
      c++;
      if (a.y_valid) begin
        if (na < 15) begin
          ya[na] = a.y_data;
          if (a.y_idx != 4'(na)) idx_bad++;
        end
        if (na == 0) first_c = c;
        else if (c - last_c != 9) gap_bad++;
        last_c = c;
        na++;
      end
      if (a.done) begin done_cnt++; done_c = c; end
      if (!a.busy) idle_c = c;
    end
    a.start = 1'b0; a.load_x = 1'b0; a.load_h = 1'b0; a.wr_addr = '0; a.din = '0;
    $display("run_a disturb=%0d outputs=%0d first=%0d done=%0d idle=%0d", disturb, na, first_c, done_c, idle_c);
  endtask

  task automatic check_a(input string tag);
    for (int i = 0; i < 15; i++) check($sformatf("%s_y%0d", tag, i), ya[i], exp_y[i]);
    check({tag, "_count"}, na, 15);
    check({tag, "_idx"}, idx_bad, 0);
    check({tag, "_end"}, idle_c, 136);
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0;
    a.start = 1'b0; a.load_x = 1'b0; a.load_h = 1'b0; a.wr_addr = '0; a.din = '0;
    b.start = 1'b0; b.load_x = 1'b0; b.load_h = 1'b0; b.wr_addr = '0; b.din = '0;

    // Reset held: activity on start/loads must not disturb anything.
    repeat (2) @(negedge clk);
    a.start = 1'b1; a.load_x = 1'b1; a.load_h = 1'b1; a.wr_addr = 3'd2; a.din = 8'd55;
    repeat (3) @(negedge clk);
    check("rst_busy", a.busy, 0);
    check("rst_valid", a.y_valid, 0);
    check("rst_done", a.done, 0);
    check("rst_ydata", a.y_data, 0);
    check("rst_yidx", a.y_idx, 0);
    a.start = 1'b0; a.load_x = 1'b0; a.load_h = 1'b0; a.wr_addr = '0; a.din = '0;
    rstn = 1'b1;
    @(negedge clk);

    // Empty memories: every output is zero.
    for (int i = 0; i < 15; i++) exp_y[i] = 0;
    run_a(1'b0);
    check_a("zero");

    // Impulse response: y = h followed by zeros.
    load_a(1, 0, 0, 1);
    for (int i = 1; i < 8; i++) load_a(1, 0, i, 0);
    for (int i = 0; i < 8; i++) load_a(0, 1, i, i + 1);
    for (int i = 0; i < 15; i++) exp_y[i] = (i < 8) ? i + 1 : 0;
    run_a(1'b0);
    check_a("impulse");

    // All ones via simultaneous x/h writes: triangular output and exact timing.
    for (int i = 0; i < 8; i++) load_a(1, 1, i, 1);
    for (int i = 0; i < 15; i++) exp_y[i] = (i < 8) ? i + 1 : 15 - i;
    run_a(1'b0);
    check_a("ones");
    check("ones_first", first_c, 8);
    check("ones_gap", gap_bad, 0);
    check("ones_done_cnt", done_cnt, 1);
    check("ones_done_at", done_c, 135);
    check("ones_hold_ydata", a.y_data, 1);
    check("ones_hold_yidx", a.y_idx, 14);

    // Same data with start/loads hammered mid-run: identical results.
    run_a(1'b1);
    check_a("disturb");
    check("disturb_done_cnt", done_cnt, 1);

    // Extremes: -128 * -128 accumulated eight deep must not wrap.
    for (int i = 0; i < 8; i++) load_a(1, 1, i, -128);
    for (int i = 0; i < 15; i++) exp_y[i] = 16384 * ((i < 8) ? i + 1 : 15 - i);
    run_a(1'b0);
    check_a("neg_neg");
    check("neg_neg_peak", ya[7], 131072);

    for (int i = 0; i < 8; i++) load_a(0, 1, i, 127);
    for (int i = 0; i < 15; i++) exp_y[i] = -16256 * ((i < 8) ? i + 1 : 15 - i);
    run_a(1'b0);
    check_a("neg_pos");
    check("neg_pos_peak", ya[7], -130048);

    // Reset mid-run: outputs drop without a clock edge, no done afterwards.
    begin
      int bad;
      bad = 0;
      a.start = 1'b1;
      @(negedge clk);
      a.start = 1'b0;
      repeat (50) @(negedge clk);
      check("mid_busy_before", a.busy, 1);
      rstn = 1'b0;
      #1;
      check("mid_busy", a.busy, 0);
      check("mid_valid", a.y_valid, 0);
      repeat (5) begin
        @(negedge clk);
        if (a.done || a.y_valid || a.busy) bad++;
      end
      check("mid_quiet", bad, 0);
      rstn = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 15; i++) exp_y[i] = 0;
    run_a(1'b0);
    check_a("after_rst");

    // N=4 build: sample writes at addresses 4..7 must be dropped.
    begin
      int c, nb, bb_first, bb_done, bb_idle;
      load_b(1, 0, 0, 1);
      for (int i = 4; i < 8; i++) load_b(1, 0, i, 5);
      for (int i = 0; i < 8; i++) load_b(0, 1, i, i + 1);
      c = 0; nb = 0; bb_first = -1; bb_done = -1; bb_idle = -1;
      b.start = 1'b1;
      @(negedge clk);
      b.start = 1'b0;
      while (c < 200 && bb_idle < 0) begin
        @(negedge clk);
        c++;
        if (b.y_valid) begin
          if (nb < 11) yb[nb] = b.y_data;
          if (nb == 0) bb_first = c;
          nb++;
        end
        if (b.done) bb_done = c;
        if (!b.busy) bb_idle = c;
      end
      $display("run_b outputs=%0d first=%0d done=%0d idle=%0d", nb, bb_first, bb_done, bb_idle);
      for (int i = 0; i < 11; i++) check($sformatf("n4_y%0d", i), yb[i], (i < 8) ? i + 1 : 0);
      check("n4_count", nb, 11);
      check("n4_first", bb_first, 4);
      check("n4_done_at", bb_done, 55);
      check("n4_end", bb_idle, 56);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
